// File: rtl/n2t_pkg.sv
// Shared widths and word type for the n2t sequential chain (ram8, ram64, pc).
package n2t_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned RAM8_ADDR_W = 3;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/bit_n2t.sv
// Single-bit load/store cell: synchronous clear, otherwise captures in when load is high.
module bit_n2t (
  input  logic clk,
  input  logic reset,
  input  logic in,
  input  logic load,
  output logic out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= 1'b0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/register_n2t.sv
// WIDTH-bit word register assembled from bit_n2t cells sharing one load and reset.
module register_n2t
  import n2t_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    bit_n2t u_bit (
      .clk  (clk),
      .reset(reset),
      .in   (in[b]),
      .load (load),
      .out  (out[b])
    );
  end

endmodule

// File: rtl/ram8_n2t.sv
// Eight-word memory: registered writes through a one-hot load demux, combinational read mux.
module ram8_n2t
  import n2t_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned ADDR_W = RAM8_ADDR_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out
);

  logic [DEPTH-1:0] word_load;
  logic [WIDTH-1:0] word_q [DEPTH];

  // At most one word sees load; none when load is low.
  always_comb begin
    word_load = '0;
    if (load) begin
      word_load[address] = 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register_n2t #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .reset(reset),
      .in   (in),
      .load (word_load[i]),
      .out  (word_q[i])
    );
  end

  // No bypass from in: a same-cycle write shows up only after the edge.
  always_comb begin
    out = word_q[address];
  end

endmodule

// File: tb/tb_ram8_n2t.sv
// Scoreboard bench for ram8_n2t: bench-side memory model feeds an expected-value queue.
`timescale 1ns/1ps
module tb_ram8_n2t;
  import n2t_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;

  logic [15:0] model [8];
  logic [15:0] exp_q [$];
  logic [15:0] exp;
  int          tests;
  int          fails;

  ram8_n2t dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in),
    .load   (load),
    .address(address),
    .out    (out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus only: one write of d to word a on the next rising edge.
  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clk);
    if (!reset) model[a] = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    write_word(3'd5, 16'h1234);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'h0000);
      address = 3'(i);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL reset_clear addr %0d: got %h, required %h", i, out, exp);
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'(16'h1111 * (i + 1)));
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'(16'h1111 * (i + 1)));
      address = 3'(i);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL write_read addr %0d: got %h, required %h", i, out, exp);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    load    = 1'b0;
    in      = 16'hFFFF;
    address = 3'd3;
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(16'h4444);
    #1;
    exp = exp_q.pop_front();
    tests++;
    if (out !== exp) begin
      fails++;
      $display("FAIL hold addr 3: got %h, required %h", out, exp);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model[i]);
      address = 3'(i);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL hold_others addr %0d: got %h, required %h", i, out, exp);
      end
    end
  endtask

  task automatic test_read_during_write();
    @(negedge clk);
    address = 3'd2;
    in      = 16'hBEEF;
    load    = 1'b1;
    exp_q.push_back(model[2]);
    #1;
    exp = exp_q.pop_front();
    tests++;
    if (out !== exp) begin
      fails++;
      $display("FAIL rdw_before_edge: got %h, required %h", out, exp);
    end
    @(posedge clk);
    model[2] = 16'hBEEF;
    exp_q.push_back(model[2]);
    #1;
    exp = exp_q.pop_front();
    tests++;
    if (out !== exp) begin
      fails++;
      $display("FAIL rdw_after_edge: got %h, required %h", out, exp);
    end
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i <= 3; i += 2) begin
      exp_q.push_back(model[i]);
      address = 3'(i);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL rdw_neighbour addr %0d: got %h, required %h", i, out, exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset   = 1'b1;
    load    = 1'b1;
    address = 3'd6;
    in      = 16'hCAFE;
    @(posedge clk);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model[i]);
      address = 3'(i);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL reset_priority addr %0d: got %h, required %h", i, out, exp);
      end
    end
  endtask

  task automatic test_comb_read_no_async_reset();
    for (int i = 0; i < 8; i++) write_word(3'(i), 16'(16'hA5A0 + i));
    @(negedge clk);
    reset = 1'b1;
    // Eight 1 ns steps stay inside the 10 ns low phase.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model[i]);
      address = 3'(i);
      #1;
      exp = exp_q.pop_front();
      tests++;
      if (out !== exp) begin
        fails++;
        $display("FAIL comb_read_reset_low addr %0d: got %h, required %h", i, out, exp);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    #1;
    exp_q.push_back(model[7]);
    exp = exp_q.pop_front();
    tests++;
    if (out !== exp) begin
      fails++;
      $display("FAIL reset_at_edge addr 7: got %h, required %h", out, exp);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b0;
    load    = 1'b0;
    in      = 16'h0000;
    address = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 16'hxxxx;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_read();
    test_hold();
    test_read_during_write();
    test_reset_priority();
    test_comb_read_no_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
